// File: rtl/irq_controller.sv
// Peripheral interrupt collector for the COP0 external-interrupt input: synchronises N lines,
// latches rising edges as pending bits, and hands one masked, priority-resolved request to COP0.
module irq_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_ack,
    input  logic             i_eret,
    input  logic             i_mask_we,
    input  logic [N_IRQ-1:0] i_mask_data,
    input  logic             i_overrun_clr,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [ID_W-1:0]  o_active_id,
    output logic             o_in_service,
    output logic [N_IRQ-1:0] o_pending,
    output logic [N_IRQ-1:0] o_mask,
    output logic [N_IRQ-1:0] o_overrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] overrun_q, overrun_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [ID_W-1:0]  active_id_q, active_id_d;

    logic [N_IRQ-1:0] edge_vec;
    logic [N_IRQ-1:0] enabled;
    logic [N_IRQ-1:0] claim_vec;
    logic [ID_W-1:0]  winner;
    logic             claim;

    // prev_q resets to 0, so a line already high at reset release yields one edge.
    assign edge_vec = sync2_q & ~prev_q;
    assign enabled  = pending_q & mask_q;
    assign claim    = (state_q == ST_REQ) && i_ack;

    // Claim decodes the id COP0 actually saw (the registered one), not this cycle's winner.
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_claim
            assign claim_vec[gi] = claim && (irq_id_q == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        winner = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (enabled[k]) begin
                winner = ID_W'(k);
            end
        end
    end

    always_comb begin
        pending_d = (pending_q & ~claim_vec) | edge_vec;
        overrun_d = (i_overrun_clr ? '0 : overrun_q) | (edge_vec & pending_q & ~claim_vec);
        mask_d    = i_mask_we ? i_mask_data : mask_q;
    end

    always_comb begin
        state_d     = state_q;
        irq_id_d    = irq_id_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                if (enabled != '0) begin
                    state_d  = ST_REQ;
                    irq_id_d = winner;
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    state_d     = ST_SERVICE;
                    active_id_d = irq_id_q;
                end else if (enabled == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    irq_id_d = winner;
                end
            end
            ST_SERVICE: begin
                if (i_eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            overrun_q   <= '0;
            irq_id_q    <= '0;
            active_id_q <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= i_irq;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            overrun_q   <= overrun_d;
            irq_id_q    <= irq_id_d;
            active_id_q <= active_id_d;
        end
    end

    assign o_irq        = (state_q == ST_REQ);
    assign o_in_service = (state_q == ST_SERVICE);
    assign o_irq_id     = irq_id_q;
    assign o_active_id  = active_id_q;
    assign o_pending    = pending_q;
    assign o_mask       = mask_q;
    assign o_overrun    = overrun_q;

endmodule
